phase_timer_hp: RTL

//  Responder for the game-control FSM's STATE output. It times the result-display states and

---
 rtl/phase_timer_hp_pkg.sv | 32 +++
 rtl/phase_timer_hp_sec_pulse_timer.sv | 45 ++++
 rtl/phase_timer_hp.sv | 76 +++++++
 3 files changed

// File: rtl/phase_timer_hp_pkg.sv
// Shared definitions for the game-control FSM and its phase timer / HP responder.
package phase_timer_hp_pkg;

  // Control FSM state codes
  localparam logic [3:0] READY    = 4'h2;
  localparam logic [3:0] QUESTION = 4'h3;
  localparam logic [3:0] INPUT    = 4'h4;
  localparam logic [3:0] DRAW     = 4'h6;
  localparam logic [3:0] WRONG    = 4'h7;
  localparam logic [3:0] GOOD     = 4'h8;
  localparam logic [3:0] OUCH     = 4'h9;
  localparam logic [3:0] WIN      = 4'hA;
  localparam logic [3:0] LOSE     = 4'hB;

  // HP_OUT win/lose codes returned to the FSM
  localparam logic [1:0] HP_GAMEON = 2'b00;
  localparam logic [1:0] HP_WIN    = 2'b01;
  localparam logic [1:0] HP_LOSE   = 2'b10;

  // Result-display states that last one second; everything else, illegal codes included, is untimed
  function automatic logic is_timed(input logic [3:0] state);
    logic timed;
    timed = 1'b0;
    case (state)
      DRAW, WRONG, GOOD, OUCH, WIN, LOSE: timed = 1'b1;
      READY, QUESTION, INPUT:             timed = 1'b0;
      default:                            timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/phase_timer_hp_sec_pulse_timer.sv
// One-second timer: counts from 1 up to CLK_HZ while run is held, emits a single
// registered pulse on reaching CLK_HZ, then holds until run drops or start restarts it.
module sec_pulse_timer
  import phase_timer_hp_pkg::*;
#(
  parameter int CLK_HZ = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic run,
  output logic pulse,
  output logic busy
);

  localparam int CW = $clog2(CLK_HZ + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLK_HZ);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;
  logic          advance;

  // A count in progress steps forward only while the same timed state persists
  assign advance = run && !start && (cnt != '0) && (cnt < CNT_END);

  // Counter and terminal pulse; the pulse fires only on the step into CLK_HZ, so it cannot repeat
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= advance && (cnt == CNT_LAST);
      if (!run) begin
        cnt <= '0;
      end else if (start) begin
        cnt <= CW'(1);
      end else if (advance) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (cnt != '0) && (cnt != CNT_END);

endmodule

// File: rtl/phase_timer_hp.sv
// Phase timer and HP keeper that answers the game-control FSM: times the result
// states (CNT1S), tracks both players' HP and reports win/lose on HP_OUT.
module phase_timer_hp
  import phase_timer_hp_pkg::*;
#(
  parameter int CLK_HZ  = 8,
  parameter int HP_INIT = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] STATE,
  output logic       CNT1S,
  output logic [1:0] HP_OUT,
  output logic [2:0] MY_HP,
  output logic [2:0] OPP_HP,
  output logic       BUSY
);

  localparam logic [2:0] HP_RELOAD = 3'(HP_INIT);

  logic [3:0] prev_q;
  logic       entry;
  logic       timed;

  // Any change of STATE is an entry, timed-to-timed included
  assign entry = (STATE != prev_q);
  assign timed = is_timed(STATE);

  // Previous-state register for edge detection; READY after reset so READY is not an entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= READY;
    end else begin
      prev_q <= STATE;
    end
  end

  // HP bookkeeping: hits decrement with saturation, leaving WIN/LOSE for READY starts a new game
  always_ff @(posedge CLK) begin
    if (RST) begin
      MY_HP  <= HP_RELOAD;
      OPP_HP <= HP_RELOAD;
    end else if (entry) begin
      if (STATE == GOOD) begin
        if (OPP_HP != 3'd0) OPP_HP <= OPP_HP - 3'd1;
      end else if (STATE == OUCH) begin
        if (MY_HP != 3'd0) MY_HP <= MY_HP - 3'd1;
      end else if ((STATE == READY) && ((prev_q == WIN) || (prev_q == LOSE))) begin
        MY_HP  <= HP_RELOAD;
        OPP_HP <= HP_RELOAD;
      end
    end
  end

  // Win/lose decode straight off the HP registers; own defeat outranks opponent defeat
  always_comb begin
    HP_OUT = HP_GAMEON;
    if (MY_HP == 3'd0) begin
      HP_OUT = HP_LOSE;
    end else if (OPP_HP == 3'd0) begin
      HP_OUT = HP_WIN;
    end
  end

  sec_pulse_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .start(entry && timed),
    .run  (timed),
    .pulse(CNT1S),
    .busy (BUSY)
  );

endmodule
